i2c_bus_arbiter: RTL
====================

# i2c_bus_arbiter

Two-master arbiter for the single open-drain I2C bus (scl/sda) that drives the OLED panel. It lets the EMPU's I2C master (master 0) and a hardware frame-refresh engine (master 1) share the pads. Grants are round-robin and handed over only at transaction boundaries, with a bus-free gap between owners. It sits between both masters and the top-level scl/sda tristate buffers in the sys_clk (54 MHz) domain.

## Interface
Parameters:
- BUF_CYCLES, 270 — bus-free gap after release before the next grant (≥4.7 µs at 54 MHz).
- TIMEOUT_CYCLES, 1_890_000 — maximum continuous SCL-low time before forced release (35 ms at 54 MHz).

Ports:
- sys_clk  in  1  system clock; the single clock of the block.
- reset_n  in  1  asynchronous, active-low reset.
- m_req  in  2  request per master; held high for the whole transaction.
- m_gnt  out  2  one-hot-or-zero grant, registered.
- m_scl_oe  in  2  per-master SCL pull-low request.
- m_sda_oe  in  2  per-master SDA pull-low request.
- scl_i  in  1  raw SCL pad input, asynchronous.
- sda_i  in  1  raw SDA pad input, asynchronous.
- scl_oe  out  1  SCL pad pull-low enable.
- sda_oe  out  1  SDA pad pull-low enable.
- bus_busy  out  1  START seen with no STOP since.
- arb_err  out  1  one-cycle pulse on a forced timeout release.

## Operation
- Pad inputs pass through a 2-FF synchronizer.
- START is SDA falling while SCL is high, both synchronized. STOP is SDA rising while SCL is high.
- bus_busy sets on START and clears on STOP.
- Pad drive: scl_oe = m_scl_oe[i] & m_gnt[i] (OR over i). sda_oe is formed the same way. A non-granted master's drive is masked. Both masters always see the true pad inputs.
- States:
  - IDLE: if any m_req is high and bus_busy=0, grant one master and go to OWN.
  - OWN: the granted master drives the bus. When its m_req falls, drop m_gnt immediately and go to DRAIN.
  - DRAIN: wait until bus_busy=0, then load the BUF counter and go to HOLDOFF. This covers a requester that drops m_req mid-transaction without issuing a STOP.
  - HOLDOFF: count BUF_CYCLES, then go to IDLE.
- Round-robin selection:
  - A pointer names the preferred master; its reset value is 0.
  - On a simultaneous request the preferred master wins.
  - After each grant the pointer moves to the other master.
  - A lone requester is granted regardless of the pointer.
- A foreign START, which can only come from an external master, blocks granting in IDLE until its STOP.
- A request raised during DRAIN or HOLDOFF waits. It is never lost while held.

## Timing
- Reset values: m_gnt=0, scl_oe=0, sda_oe=0, bus_busy=0, arb_err=0, pointer=0, state IDLE. Synchronizer flops reset to 1 (idle bus).
- Reset takes effect asynchronously at any time, including mid-transaction. Pad drive releases immediately.
- Grant latency: m_req sampled high in IDLE gives m_gnt high on the next sys_clk edge.
- Release latency: m_req sampled low in OWN gives m_gnt low on the next edge.
- Pad drive is combinational from the registered m_gnt, so there is zero added latency from m_*_oe to the pads.
- Bus-event latency:
  - START/STOP detection: 3 cycles after the pad edge (2 synchronizer + 1 edge register).
  - bus_busy updates one cycle after detection.
- Minimum gap between two grants: BUF_CYCLES + 2 cycles after bus_busy clears.
- Counters are sized $clog2(param+1) and saturate; they do not wrap.

## Configuration
- I2C_ARB_TIMEOUT_EN defined:
  - In OWN, a counter runs while synchronized SCL is low and clears while SCL is high.
  - When it reaches TIMEOUT_CYCLES: m_gnt is dropped, arb_err pulses for 1 cycle, bus_busy is forced to 0, and the state goes to HOLDOFF.
  - The timed-out master keeps its request. It is re-granted only after the other master is served, if the other master is requesting.
- Not defined: no timeout counter and arb_err is tied to 0. A stuck owner holds the bus until it drops m_req or reset is applied.

## Structure
- Package i2c_arb_pkg holds:
  - the state enum (IDLE, OWN, DRAIN, HOLDOFF);
  - master index constants M_CPU=0 and M_REFRESH=1;
  - the NUM_MASTERS=2 constant.
- Sub-module i2c_bus_monitor contains the synchronizers, START/STOP detection and bus_busy. It outputs scl_s, sda_s, start_p, stop_p and busy.
- The arbiter FSM, round-robin pointer, counters and output masking live in i2c_bus_arbiter.

## Test plan
- Reset then m_req=2'b01 → m_gnt=2'b01 exactly 1 cycle later. m_scl_oe[0]=1 gives scl_oe=1, while m_scl_oe[1]=1 alone gives scl_oe=0.
- Both masters request in the same cycle after reset → master 0 is granted. Master 0 runs START…STOP and drops req; master 1 is granted BUF_CYCLES+2 cycles after the STOP is detected.
- Master 0 drops req mid-byte with no STOP → grant drops next cycle and the state stays in DRAIN. A STOP driven by the bench → master 1 is granted after HOLDOFF.
- External START on the pads with both grants low, then m_req=2'b10 → no grant until the external STOP, then grant after BUF_CYCLES+2.
- With I2C_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100, master 1 holds SCL low for 100 cycles → arb_err pulses once, m_gnt=0, scl_oe=0, and a pending master 0 is granted next.
- reset_n asserted while master 1 is driving SDA low → sda_oe=0 and m_gnt=0 immediately with no clock edge. After reset release, the pointer favours master 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// ---------------------------------------------------------------------------
// i2c_arb_pkg
// Shared definitions for the two-master I2C bus arbiter.
//   - arb_state_e : arbiter FSM states (IDLE, OWN, DRAIN, HOLDOFF)
//   - M_CPU / M_REFRESH : master indices (EMPU I2C master, frame-refresh engine)
//   - NUM_MASTERS : number of arbitrated masters
//   - onehot()    : grant vector for a master index
// ---------------------------------------------------------------------------
package i2c_arb_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int M_CPU       = 0;
  localparam int M_REFRESH   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN     = 2'd1,
    DRAIN   = 2'd2,
    HOLDOFF = 2'd3
  } arb_state_e;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic idx);
    logic [NUM_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// ---------------------------------------------------------------------------
// i2c_bus_monitor
// Synchronizes the raw SCL/SDA pad inputs, detects START/STOP conditions and
// tracks bus ownership (bus_busy).
// Ports:
//   sys_clk, reset_n  : clock, async active-low reset
//   scl_i, sda_i      : raw asynchronous pad inputs
//   busy_clr          : forces busy low (timeout recovery)
//   scl_s, sda_s      : synchronized pad levels
//   start_p, stop_p   : one-cycle START / STOP pulses (3 cycles after pad edge)
//   busy              : START seen with no STOP since
// ---------------------------------------------------------------------------
module i2c_bus_monitor
  import i2c_arb_pkg::*;
(
  input  logic sys_clk,
  input  logic reset_n,
  input  logic scl_i,
  input  logic sda_i,
  input  logic busy_clr,
  output logic scl_s,
  output logic sda_s,
  output logic start_p,
  output logic stop_p,
  output logic busy
);

  logic scl_m, sda_m, sda_d;

  // NOTE: synchronizer flops reset to 1 so that leaving reset looks like an
  // idle bus and no spurious START/STOP is decoded.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_m   <= 1'b1;
      scl_s   <= 1'b1;
      sda_m   <= 1'b1;
      sda_s   <= 1'b1;
      sda_d   <= 1'b1;
      start_p <= 1'b0;
      stop_p  <= 1'b0;
    end else begin
      scl_m   <= scl_i;
      scl_s   <= scl_m;
      sda_m   <= sda_i;
      sda_s   <= sda_m;
      sda_d   <= sda_s;
      // SDA edge while SCL is high marks a START (falling) or STOP (rising)
      start_p <= scl_s &  sda_d & ~sda_s;
      stop_p  <= scl_s & ~sda_d &  sda_s;
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)      busy <= 1'b0;
    else if (busy_clr) busy <= 1'b0;
    else if (start_p)  busy <= 1'b1;
    else if (stop_p)   busy <= 1'b0;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_bus_arbiter
// Round-robin arbiter letting two I2C masters share one open-drain bus.
// Grants change only at transaction boundaries and are separated by a
// BUF_CYCLES bus-free gap.
// Optional feature: define I2C_ARB_TIMEOUT_EN to force release of an owner
// that holds SCL low for TIMEOUT_CYCLES (arb_err pulses); otherwise arb_err=0.
// Ports:
//   sys_clk, reset_n     : clock, async active-low reset
//   m_req[1:0]           : per-master request, held for the whole transaction
//   m_gnt[1:0]           : registered one-hot-or-zero grant
//   m_scl_oe, m_sda_oe   : per-master pull-low requests
//   scl_i, sda_i         : raw pad inputs
//   scl_oe, sda_oe       : pad pull-low enables (granted master only)
//   bus_busy             : START seen with no STOP since
//   arb_err              : one-cycle pulse on forced timeout release
// ---------------------------------------------------------------------------
module i2c_bus_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int BUF_CYCLES     = 270,
  parameter int TIMEOUT_CYCLES = 1_890_000
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic [NUM_MASTERS-1:0] m_req,
  output logic [NUM_MASTERS-1:0] m_gnt,
  input  logic [NUM_MASTERS-1:0] m_scl_oe,
  input  logic [NUM_MASTERS-1:0] m_sda_oe,
  input  logic                   scl_i,
  input  logic                   sda_i,
  output logic                   scl_oe,
  output logic                   sda_oe,
  output logic                   bus_busy,
  output logic                   arb_err
);

  localparam int BUF_W = (BUF_CYCLES > 0) ? $clog2(BUF_CYCLES + 1) : 1;

  arb_state_e       state;
  logic             ptr;
  logic             owner;
  logic             win;
  logic [BUF_W-1:0] buf_cnt;
  logic             to_fire;
  logic             scl_s, sda_s, start_p, stop_p;

  i2c_bus_monitor u_mon (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .busy_clr (to_fire),
    .scl_s    (scl_s),
    .sda_s    (sda_s),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .busy     (bus_busy)
  );

  // Pads follow the registered grant combinationally: no added latency and an
  // asynchronous reset releases the bus at once.
  assign scl_oe = |(m_scl_oe & m_gnt);
  assign sda_oe = |(m_sda_oe & m_gnt);

  // A lone requester wins regardless of the pointer; a tie goes to the pointer.
  // NOTE: every combinational output gets a default first, so no latch forms.
  always_comb begin
    win = ptr;
    if (m_req[M_CPU] && !m_req[M_REFRESH])      win = 1'(M_CPU);
    else if (!m_req[M_CPU] && m_req[M_REFRESH]) win = 1'(M_REFRESH);
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  assign to_fire = (state == OWN) && (to_cnt == TO_W'(TIMEOUT_CYCLES));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt  <= '0;
      arb_err <= 1'b0;
    end else begin
      arb_err <= to_fire;
      if (state != OWN || scl_s)                to_cnt <= '0;
      else if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign arb_err = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      m_gnt   <= '0;
      ptr     <= 1'b0;
      owner   <= 1'b0;
      buf_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A foreign transaction must finish and be followed by a full gap.
          if (bus_busy) begin
            state <= DRAIN;
          end else if (|m_req) begin
            m_gnt <= onehot(win);
            owner <= win;
            ptr   <= ~win;
            state <= OWN;
          end
        end
        OWN: begin
          if (to_fire) begin
            m_gnt   <= '0;
            buf_cnt <= BUF_W'(BUF_CYCLES);
            state   <= HOLDOFF;
          end else if (!m_req[owner]) begin
            m_gnt <= '0;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!bus_busy) begin
            buf_cnt <= BUF_W'(BUF_CYCLES);
            state   <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // Counts down to 1 rather than 0 so the grant lands BUF_CYCLES+2
          // cycles after bus_busy falls; it never decrements below 1.
          if (bus_busy)                    state   <= DRAIN;
          else if (buf_cnt <= BUF_W'(1))   state   <= IDLE;
          else                             buf_cnt <= buf_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, scl_s, sda_s, start_p, stop_p, (TIMEOUT_CYCLES != 0)};

endmodule
